mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Single-core memory arbiter sitting directly downstream of the i/d cache block.
- Consumes the cache-side request signals (iREN/iaddr, dREN/dWEN/daddr/dstore) and serialises them onto one single-ported RAM port with variable latency.
- Returns iwait/dwait and iload/dload to the caches.
- Data requests have priority. A streak counter prevents instruction starvation.

Parameters:
- MAX_DSTREAK, 4: number of consecutive data grants allowed while an instruction request is pending; the next grant then goes to instruction.
- ADDR_W, 32: address and data width.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- iREN  in  1  instruction read request.
- iaddr  in  ADDR_W  instruction address.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  ADDR_W  data address.
- dstore  in  ADDR_W  data write value.
- iwait  out  1  instruction not complete.
- dwait  out  1  data not complete.
- iload  out  ADDR_W  instruction read data.
- dload  out  ADDR_W  data read data.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  ADDR_W  RAM write data.
- ramload  in  ADDR_W  RAM read data.
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- ramerr  out  1  sticky error flag.

Behaviour:
- Reset values:
  - State = IDLE, dstreak = 0, ramerr = 0.
  - ramREN = ramWEN = 0; ramaddr = ramstore = 0.
  - iwait = dwait = 1; iload = dload = 0.
- States:
  - IDLE: RAM enables low; iwait = dwait = 1. Next state is chosen from the requests sampled this cycle:
    - Data pending (dREN|dWEN), and not (iREN && dstreak == MAX_DSTREAK) -> DGRANT.
    - Else iREN -> IGRANT.
    - Else stay in IDLE.
    - On entering a grant, latch the granted address, write data and write flag into holding registers.
  - DGRANT:
    - ramaddr/ramstore come from the holding registers.
    - ramWEN = latched write flag; ramREN = !latched write flag. dWEN takes precedence if both dREN and dWEN were high.
    - dwait = 1 until ramstate ∈ {ACCESS, ERROR}. In that cycle dwait = 0 and dload = ramload (combinational). Next state IDLE.
  - IGRANT: same as DGRANT but read-only, using iwait/iload.
- Latency: request sampled at cycle t, RAM driven from t+1, earliest completion at t+1 (0-wait RAM). Minimum turnaround is 2 cycles per access; IDLE is revisited between back-to-back accesses.
- Abort: if the granted requester drops all its enables during a grant, RAM enables go low the same cycle (gated by the live enable). Next state IDLE, no completion pulse.
- The non-granted side sees wait = 1 throughout. iload/dload are 0 when that side is not completing.
- dstreak:
  - Increments (saturating at MAX_DSTREAK) on each DGRANT entry while iREN = 1.
  - Clears on IGRANT entry, or in any IDLE cycle with iREN = 0.
- ramerr: set on any completion with ramstate = ERROR. It stays set until RST. The transfer still completes; load returns ramload as-is.
- ramstate = FREE or BUSY during a grant: hold the current state and outputs.
- RST asserted mid-grant: all registers return to reset values on the next edge, and RAM enables drop immediately after that edge.

Decomposition:
- Shared package mem_arb_pkg holds:
  - ramstate_t enum (FREE/BUSY/ACCESS/ERROR).
  - arb_state_t enum (IDLE/IGRANT/DGRANT).
  - word_t typedef.
- No sub-module is required. The streak counter may optionally be split out as streak_counter (saturating, clearable).

Test Plan:
- I-fetch alone: iREN = 1, iaddr = 0x0000_0040, ramstate = ACCESS in cycle 2, ramload = 0x2408_0001 -> ramREN high from cycle 1; iwait = 0 and iload = 0x2408_0001 in cycle 2 only; dwait = 1 throughout.
- Data write with 2 BUSY cycles: dWEN = 1, daddr = 0x80, dstore = 0xDEAD_BEEF, ramstate BUSY, BUSY, ACCESS -> ramWEN = 1, ramaddr = 0x80, ramstore = 0xDEAD_BEEF for 3 cycles; dwait = 0 on the third; ramREN = 0 throughout.
- Simultaneous requests: iREN = dREN = 1 from reset -> first grant DGRANT, next IGRANT only after MAX_DSTREAK = 4 data completions if dREN stays high. Verify the 5th grant is IGRANT and dstreak returns to 0.
- ERROR response: dREN = 1, ramstate = ERROR, ramload = 0x1234 -> dwait = 0, dload = 0x1234, ramerr = 1 and remains 1 after 10 idle cycles; cleared only by RST.
- Abort and reset mid-grant:
  - dREN dropped in the second BUSY cycle -> ramREN = 0 that cycle, state IDLE next, no dwait = 0 pulse.
  - RST during IGRANT -> all outputs at reset values on the following cycle.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter: RAM handshake states,
// arbiter FSM states and the common word type.
package mem_arb_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } arb_state_t;

    // A RAM access finishes on ACCESS or ERROR; both end the transfer.
    function automatic logic is_done(ramstate_t s);
        return (s == ACCESS) || (s == ERROR);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side request/response bus and RAM-side port of the arbiter.
// master drives requests and RAM responses; slave is the arbiter.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32
) ();
    import mem_arb_pkg::*;

    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [ADDR_W-1:0] dstore;
    logic              iwait;
    logic              dwait;
    logic [ADDR_W-1:0] iload;
    logic [ADDR_W-1:0] dload;
    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [ADDR_W-1:0] ramstore;
    logic [ADDR_W-1:0] ramload;
    ramstate_t         ramstate;
    logic              ramerr;

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore,
        output ramload, ramstate,
        input  iwait, dwait, iload, dload,
        input  ramREN, ramWEN, ramaddr, ramstore, ramerr
    );

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore,
        input  ramload, ramstate,
        output iwait, dwait, iload, dload,
        output ramREN, ramWEN, ramaddr, ramstore, ramerr
    );

endinterface

// File: rtl/mem_arbiter.sv
// Serialises i-fetch and data requests onto one variable-latency
// RAM port; data wins unless the instruction side has been starved.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_DSTREAK = 4,
    parameter int ADDR_W      = 32
) (
    input logic          CLK,
    input logic          RST,
    mem_arbiter_if.slave bus
);

    localparam int SW = $clog2(MAX_DSTREAK + 1);
    localparam logic [SW-1:0] SMAX = SW'(MAX_DSTREAK);

    arb_state_t        state;
    arb_state_t        state_n;
    logic [SW-1:0]     dstreak;
    logic [ADDR_W-1:0] hold_addr;
    logic [ADDR_W-1:0] hold_store;
    logic              hold_wen;
    logic              ramerr_q;
    logic              d_live;
    logic              complete;

    assign d_live     = bus.dREN | bus.dWEN;
    assign bus.ramerr = ramerr_q;

    // State register and grant-time capture of the winning request
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            hold_addr  <= '0;
            hold_store <= '0;
            hold_wen   <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && state_n == DGRANT) begin
                hold_addr  <= bus.daddr;
                hold_store <= bus.dstore;
                hold_wen   <= bus.dWEN;
            end else if (state == IDLE && state_n == IGRANT) begin
                hold_addr  <= bus.iaddr;
                hold_store <= '0;
                hold_wen   <= 1'b0;
            end
        end
    end

    // Count data grants that overtook a waiting instruction fetch
    always_ff @(posedge CLK) begin
        if (RST) begin
            dstreak <= '0;
        end else if (state == IDLE) begin
            if (!bus.iREN || state_n == IGRANT) begin
                dstreak <= '0;
            end else if (state_n == DGRANT && dstreak != SMAX) begin
                dstreak <= dstreak + 1'b1;
            end
        end
    end

    // Sticky flag for any transfer that completed with a RAM error
    always_ff @(posedge CLK) begin
        if (RST) begin
            ramerr_q <= 1'b0;
        end else if (complete && bus.ramstate == ERROR) begin
            ramerr_q <= 1'b1;
        end
    end

    // Next-state selection and RAM/cache-side outputs
    always_comb begin
        state_n      = state;
        complete     = 1'b0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;
        bus.iload    = '0;
        bus.dload    = '0;
        unique case (state)
            IDLE: begin
                if (d_live && !(bus.iREN && dstreak == SMAX)) begin
                    state_n = DGRANT;
                end else if (bus.iREN) begin
                    state_n = IGRANT;
                end
            end
            DGRANT: begin
                bus.ramaddr  = hold_addr;
                bus.ramstore = hold_store;
                bus.ramWEN   = hold_wen & d_live;
                bus.ramREN   = ~hold_wen & d_live;
                if (!d_live) begin
                    state_n = IDLE;
                end else if (is_done(bus.ramstate)) begin
                    complete  = 1'b1;
                    bus.dwait = 1'b0;
                    bus.dload = bus.ramload;
                    state_n   = IDLE;
                end
            end
            IGRANT: begin
                bus.ramaddr = hold_addr;
                bus.ramREN  = bus.iREN;
                if (!bus.iREN) begin
                    state_n = IDLE;
                end else if (is_done(bus.ramstate)) begin
                    complete  = 1'b1;
                    bus.iwait = 1'b0;
                    bus.iload = bus.ramload;
                    state_n   = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed cases from the test plan, then
// randomized traffic against a RAM model and per-side scoreboards.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    typedef struct {
        word_t addr;
        logic  wen;
        word_t store;
        word_t load;
        logic  chk_load;
    } exp_t;

    logic      CLK;
    logic      RST;
    logic      mon_en;
    logic      ram_auto;
    ramstate_t dir_state;
    word_t     dir_load;
    int        compared;
    int        mismatched;
    exp_t      iq[$];
    exp_t      dq[$];
    word_t     refmem[word_t];
    word_t     ram_mem[word_t];
    int        busy_left;
    logic      in_acc;

    mem_arbiter_if #(.ADDR_W(32)) bus ();

    mem_arbiter #(.MAX_DSTREAK(4), .ADDR_W(32)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic word_t pat(word_t a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic word_t ref_rd(word_t a);
        if (refmem.exists(a)) return refmem[a];
        return pat(a);
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(string name, word_t act, word_t exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h want %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic chk_reset(string tag);
        chk({tag, "_iwait"}, 32'(bus.iwait), 32'd1);
        chk({tag, "_dwait"}, 32'(bus.dwait), 32'd1);
        chk({tag, "_ramREN"}, 32'(bus.ramREN), 32'd0);
        chk({tag, "_ramWEN"}, 32'(bus.ramWEN), 32'd0);
        chk({tag, "_ramaddr"}, bus.ramaddr, 32'd0);
        chk({tag, "_ramstore"}, bus.ramstore, 32'd0);
        chk({tag, "_iload"}, bus.iload, 32'd0);
        chk({tag, "_dload"}, bus.dload, 32'd0);
        chk({tag, "_ramerr"}, 32'(bus.ramerr), 32'd0);
    endtask

    // RAM device: scripted in directed cases, random latency otherwise
    always @(posedge CLK) begin
        #2;
        if (!ram_auto) begin
            bus.ramstate = dir_state;
            bus.ramload  = dir_load;
            in_acc       = 1'b0;
        end else if (bus.ramREN || bus.ramWEN) begin
            if (!in_acc) begin
                in_acc    = 1'b1;
                busy_left = $urandom_range(0, 3);
            end
            if (busy_left > 0) begin
                busy_left--;
                bus.ramstate = ($urandom_range(0, 1) == 0) ? BUSY : FREE;
                bus.ramload  = $urandom;
            end else begin
                in_acc       = 1'b0;
                bus.ramstate = ACCESS;
                if (bus.ramWEN) begin
                    ram_mem[bus.ramaddr] = bus.ramstore;
                    bus.ramload = $urandom;
                end else if (ram_mem.exists(bus.ramaddr)) begin
                    bus.ramload = ram_mem[bus.ramaddr];
                end else begin
                    bus.ramload = pat(bus.ramaddr);
                end
            end
        end else begin
            in_acc       = 1'b0;
            bus.ramstate = FREE;
            bus.ramload  = $urandom;
        end
    end

    // Monitor: pop the expected response on every completion
    always @(negedge CLK) begin
        exp_t e;
        if (mon_en) begin
            compared++;
            if (!bus.iwait && !bus.dwait) begin
                mismatched++;
                $display("FAIL both_complete: iwait=0 dwait=0 want one");
            end
            if (!bus.iwait) begin
                compared++;
                if (iq.size() == 0) begin
                    mismatched++;
                    $display("FAIL i_unexpected: iwait=0 want 1 at %0t",
                             $time);
                end else begin
                    e = iq.pop_front();
                    if (bus.iload !== e.load || bus.ramaddr !== e.addr ||
                        bus.ramREN !== 1'b1) begin
                        mismatched++;
                        $display("FAIL i_resp: load %h addr %h ren %b want %h %h 1",
                                 bus.iload, bus.ramaddr, bus.ramREN,
                                 e.load, e.addr);
                    end
                end
            end else begin
                compared++;
                if (bus.iload !== '0) begin
                    mismatched++;
                    $display("FAIL iload_idle: got %h want 0", bus.iload);
                end
            end
            if (!bus.dwait) begin
                compared++;
                if (dq.size() == 0) begin
                    mismatched++;
                    $display("FAIL d_unexpected: dwait=0 want 1 at %0t",
                             $time);
                end else begin
                    e = dq.pop_front();
                    if (bus.ramaddr !== e.addr || bus.ramWEN !== e.wen ||
                        bus.ramREN !== !e.wen ||
                        (e.wen && bus.ramstore !== e.store) ||
                        (e.chk_load && bus.dload !== e.load)) begin
                        mismatched++;
                        $display("FAIL d_resp: addr %h wen %b ren %b st %h ld %h want %h %b %h %h",
                                 bus.ramaddr, bus.ramWEN, bus.ramREN,
                                 bus.ramstore, bus.dload,
                                 e.addr, e.wen, e.store, e.load);
                    end
                end
            end else begin
                compared++;
                if (bus.dload !== '0) begin
                    mismatched++;
                    $display("FAIL dload_idle: got %h want 0", bus.dload);
                end
            end
        end
    end

    task automatic run_i(int n);
        exp_t e;
        int   cnt;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 2)) step();
            e.addr     = 32'h8000 + 4 * $urandom_range(0, 255);
            e.wen      = 1'b0;
            e.store    = '0;
            e.load     = pat(e.addr);
            e.chk_load = 1'b1;
            iq.push_back(e);
            bus.iREN  = 1'b1;
            bus.iaddr = e.addr;
            cnt = 0;
            do begin
                @(negedge CLK);
                cnt++;
            end while (bus.iwait && cnt < 80);
            if (bus.iwait) begin
                compared++;
                mismatched++;
                $display("FAIL i_timeout: iwait=1 want 0 within 80");
            end
            step();
            bus.iREN = 1'b0;
        end
    endtask

    task automatic run_d(int n);
        exp_t e;
        int   cnt;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 2)) step();
            e.wen      = 1'($urandom_range(0, 1));
            e.addr     = 32'h1000 + 4 * $urandom_range(0, 7);
            e.store    = $urandom;
            e.chk_load = !e.wen;
            if (e.wen) begin
                refmem[e.addr] = e.store;
                e.load = '0;
            end else begin
                e.load = ref_rd(e.addr);
            end
            dq.push_back(e);
            bus.dWEN   = e.wen;
            bus.dREN   = !e.wen || ($urandom_range(0, 3) == 0);
            bus.daddr  = e.addr;
            bus.dstore = e.store;
            cnt = 0;
            do begin
                @(negedge CLK);
                cnt++;
            end while (bus.dwait && cnt < 80);
            if (bus.dwait) begin
                compared++;
                mismatched++;
                $display("FAIL d_timeout: dwait=1 want 0 within 80");
            end
            step();
            bus.dREN = 1'b0;
            bus.dWEN = 1'b0;
        end
    endtask

    initial begin
        exp_t e;
        int   run;
        logic take_i;
        compared   = 0;
        mismatched = 0;
        mon_en     = 1'b0;
        ram_auto   = 1'b0;
        dir_state  = FREE;
        dir_load   = '0;
        busy_left  = 0;
        in_acc     = 1'b0;
        RST        = 1'b1;
        bus.iREN   = 1'b0;
        bus.iaddr  = '0;
        bus.dREN   = 1'b0;
        bus.dWEN   = 1'b0;
        bus.daddr  = '0;
        bus.dstore = '0;
        repeat (3) step();
        #4 chk_reset("reset");
        mon_en = 1'b1;
        step();
        RST = 1'b0;

        // I-fetch alone, FREE then ACCESS
        bus.iREN  = 1'b1;
        bus.iaddr = 32'h40;
        dir_state = FREE;
        step();
        #4 chk("if_ren_c1", 32'(bus.ramREN), 32'd1);
        chk("if_addr_c1", bus.ramaddr, 32'h40);
        chk("if_iwait_c1", 32'(bus.iwait), 32'd1);
        step();
        dir_state = ACCESS;
        dir_load  = 32'h2408_0001;
        e = '{addr: 32'h40, wen: 1'b0, store: '0,
              load: 32'h2408_0001, chk_load: 1'b1};
        iq.push_back(e);
        #4 chk("if_dwait_c2", 32'(bus.dwait), 32'd1);
        step();
        bus.iREN  = 1'b0;
        dir_state = FREE;
        #4 chk("if_iwait_c3", 32'(bus.iwait), 32'd1);
        chk("if_ren_c3", 32'(bus.ramREN), 32'd0);

        // Data write with two BUSY cycles
        step();
        bus.dWEN   = 1'b1;
        bus.daddr  = 32'h80;
        bus.dstore = 32'hDEAD_BEEF;
        dir_state  = BUSY;
        for (int c = 0; c < 2; c++) begin
            step();
            #4 chk("wr_wen_busy", 32'(bus.ramWEN), 32'd1);
            chk("wr_ren_busy", 32'(bus.ramREN), 32'd0);
            chk("wr_addr_busy", bus.ramaddr, 32'h80);
            chk("wr_store_busy", bus.ramstore, 32'hDEAD_BEEF);
            chk("wr_dwait_busy", 32'(bus.dwait), 32'd1);
        end
        step();
        dir_state = ACCESS;
        e = '{addr: 32'h80, wen: 1'b1, store: 32'hDEAD_BEEF,
              load: '0, chk_load: 1'b0};
        dq.push_back(e);
        #4 chk("wr_dwait_done", 32'(bus.dwait), 32'd0);
        step();
        bus.dWEN  = 1'b0;
        dir_state = FREE;
        #4 chk("wr_wen_after", 32'(bus.ramWEN), 32'd0);

        // Simultaneous requests: four data grants then one fetch
        step();
        RST = 1'b1;
        step();
        RST       = 1'b0;
        bus.iREN  = 1'b1;
        bus.iaddr = 32'h100;
        bus.dREN  = 1'b1;
        bus.daddr = 32'h200;
        dir_state = ACCESS;
        run = 0;
        for (int g = 0; g < 10; g++) begin
            step();
            dir_load = 32'hA000_0000 + 32'(g);
            take_i   = (run == 4);
            run      = take_i ? 0 : run + 1;
            e = '{addr: take_i ? 32'h100 : 32'h200, wen: 1'b0,
                  store: '0, load: dir_load, chk_load: 1'b1};
            if (take_i) iq.push_back(e);
            else dq.push_back(e);
            #4 chk("sim_grant_addr", bus.ramaddr, e.addr);
            chk("sim_grant_ren", 32'(bus.ramREN), 32'd1);
            step();
            if (g == 9) begin
                bus.iREN = 1'b0;
                bus.dREN = 1'b0;
            end
            #4 chk("sim_idle_ren", 32'(bus.ramREN), 32'd0);
        end

        // ERROR completion and sticky ramerr
        step();
        dir_state = FREE;
        bus.dREN  = 1'b1;
        bus.daddr = 32'h300;
        step();
        dir_state = ERROR;
        dir_load  = 32'h1234;
        e = '{addr: 32'h300, wen: 1'b0, store: '0,
              load: 32'h1234, chk_load: 1'b1};
        dq.push_back(e);
        #4 chk("err_dwait", 32'(bus.dwait), 32'd0);
        step();
        bus.dREN  = 1'b0;
        dir_state = FREE;
        #4 chk("err_flag_set", 32'(bus.ramerr), 32'd1);
        repeat (10) step();
        #4 chk("err_flag_hold", 32'(bus.ramerr), 32'd1);
        step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        #4 chk("err_flag_clr", 32'(bus.ramerr), 32'd0);

        // Abort: dREN dropped in the second BUSY cycle
        step();
        bus.dREN  = 1'b1;
        bus.daddr = 32'h400;
        dir_state = BUSY;
        step();
        #4 chk("ab_ren_c1", 32'(bus.ramREN), 32'd1);
        step();
        bus.dREN = 1'b0;
        #4 chk("ab_ren_drop", 32'(bus.ramREN), 32'd0);
        chk("ab_dwait_drop", 32'(bus.dwait), 32'd1);
        step();
        dir_state = ACCESS;
        #4 chk("ab_ren_idle", 32'(bus.ramREN), 32'd0);
        chk("ab_dwait_idle", 32'(bus.dwait), 32'd1);

        // Reset asserted during an instruction grant
        step();
        dir_state = BUSY;
        bus.iREN  = 1'b1;
        bus.iaddr = 32'h500;
        step();
        RST = 1'b1;
        #4 chk("rg_ren_c1", 32'(bus.ramREN), 32'd1);
        step();
        RST      = 1'b0;
        bus.iREN = 1'b0;
        #4 chk_reset("rst_mid");

        // Randomized mixed traffic
        step();
        ram_auto = 1'b1;
        fork
            run_i(40);
            run_d(40);
        join
        repeat (5) step();
        #4 chk("iq_empty", 32'(iq.size()), 32'd0);
        chk("dq_empty", 32'(dq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
